seg_scan_disp: RTL and testbench



---
 rtl/seg_scan_disp.sv | 118 +++++++++++
 tb/tb_seg_scan_disp.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_disp.sv
// seg_scan_disp
// Time-multiplexed 4-digit common-anode 7-segment driver. Shadows four BCD
// digits from the measurement block, scans them right-to-left-indexed
// (digit 0 = units) with a blanking gap at the start of each digit slot,
// and applies optional leading-zero blanking and per-digit decimal points.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   seg0..3   BCD digits, seg0 = units, seg3 = thousands
//   load      shadow registers capture seg0..seg3 on this edge when high
//   blank_lz  enable leading-zero blanking on digits 3..1
//   dp_en     bit k lights the decimal point of digit k
//   seg_sel   digit enables, active-low, at most one low
//   seg_led   segments {dp,g,f,e,d,c,b,a}, active-low
//
// BLANK_CYC must satisfy 1 <= BLANK_CYC < DIG_CYC.

module seg_scan_disp #(
   parameter int CLK_FRE    = 26'd12_000_000,
   parameter int REFRESH_HZ = 250,
   parameter int BLANK_CYC  = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] seg0,
   input  logic [3:0] seg1,
   input  logic [3:0] seg2,
   input  logic [3:0] seg3,
   input  logic       load,
   input  logic       blank_lz,
   input  logic [3:0] dp_en,
   output logic [3:0] seg_sel,
   output logic [7:0] seg_led
);

   localparam int DIG_CYC = CLK_FRE / (4 * REFRESH_HZ);
   localparam int CNT_W   = (DIG_CYC > 1) ? $clog2(DIG_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIG_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

   logic [CNT_W-1:0] pre_cnt;
   logic [1:0]       idx;
   logic [3:0]       sh [4];

   logic [3:0]       lz_blank;
   logic [3:0]       cur_digit;
   logic [3:0]       seg_sel_d;
   logic [7:0]       seg_led_d;

   // Returns {g,f,e,d,c,b,a}, active-low. Codes 10..15 show a dash.
   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] r;
      case (d)
         4'd0:    r = 7'h40;
         4'd1:    r = 7'h79;
         4'd2:    r = 7'h24;
         4'd3:    r = 7'h30;
         4'd4:    r = 7'h19;
         4'd5:    r = 7'h12;
         4'd6:    r = 7'h02;
         4'd7:    r = 7'h78;
         4'd8:    r = 7'h00;
         4'd9:    r = 7'h10;
         default: r = 7'h3F;
      endcase
      return r;
   endfunction

   // A digit is a leading zero only if it and every more-significant digit
   // are zero; invalid codes are non-zero and stop the chain.
   always_comb begin
      lz_blank    = 4'b0000;
      lz_blank[3] = blank_lz && (sh[3] == 4'd0);
      lz_blank[2] = lz_blank[3] && (sh[2] == 4'd0);
      lz_blank[1] = lz_blank[2] && (sh[1] == 4'd0);
   end

   always_comb begin
      cur_digit = sh[idx];
      seg_sel_d = 4'b1111;
      seg_led_d = 8'hFF;
      if (pre_cnt >= CNT_BLANK) begin
         seg_sel_d      = ~(4'b0001 << idx);
         seg_led_d[6:0] = lz_blank[idx] ? 7'h7F : decode(cur_digit);
         seg_led_d[7]   = ~dp_en[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         idx     <= 2'd0;
         sh[0]   <= 4'd0;
         sh[1]   <= 4'd0;
         sh[2]   <= 4'd0;
         sh[3]   <= 4'd0;
         seg_sel <= 4'b1111;
         seg_led <= 8'hFF;
      end else begin
         if (pre_cnt == CNT_LAST) begin
            pre_cnt <= '0;
            idx     <= idx + 2'd1;
         end else begin
            pre_cnt <= pre_cnt + CNT_W'(1);
         end
         if (load) begin
            sh[0] <= seg0;
            sh[1] <= seg1;
            sh[2] <= seg2;
            sh[3] <= seg3;
         end
         seg_sel <= seg_sel_d;
         seg_led <= seg_led_d;
      end
   end

endmodule

// File: tb/tb_seg_scan_disp.sv
module tb_seg_scan_disp;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] seg0, seg1, seg2, seg3;
   logic       load;
   logic       blank_lz;
   logic [3:0] dp_en;
   logic [3:0] seg_sel;
   logic [7:0] seg_led;

   int checks   = 0;
   int failures = 0;

   logic [3:0] sel_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [3:0] cap_sel [40];
   logic [7:0] cap_led [40];

   seg_scan_disp #(
      .CLK_FRE(400),
      .REFRESH_HZ(10),
      .BLANK_CYC(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .seg0(seg0),
      .seg1(seg1),
      .seg2(seg2),
      .seg3(seg3),
      .load(load),
      .blank_lz(blank_lz),
      .dp_en(dp_en),
      .seg_sel(seg_sel),
      .seg_led(seg_led)
   );

   always #5 clk = ~clk;

   task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                             input logic [3:0] d1, input logic [3:0] d0);
      seg3 = d3; seg2 = d2; seg1 = d1; seg0 = d0;
   endtask

   task automatic apply_reset(input int n);
      rst_n = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
   endtask

   // Records one full 40-edge scan; entry i holds the outputs registered
   // from pre_cnt = i%10, idx = i/10 when started at a frame boundary.
   task automatic capture_frame(input bit pulse_load);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         cap_sel[i] = seg_sel;
         cap_led[i] = seg_led;
         if (pulse_load && i == 0) load = 1'b0;
      end
   endtask

   task automatic test_reset;
      set_digits(4'd9, 4'd9, 4'd9, 4'd9);
      load = 1'b1; blank_lz = 1'b0; dp_en = 4'b0000;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (seg_sel !== 4'b1111 || seg_led !== 8'hFF) begin
            failures++;
            $display("FAIL reset_hold cyc=%0d got sel=%b led=%h want sel=1111 led=ff", i, seg_sel, seg_led);
         end
      end
      rst_n = 1'b1;
      for (int n = 1; n <= 3; n++) begin
         @(posedge clk); #1;
         checks++;
         if (n < 3 && (seg_sel !== 4'b1111 || seg_led !== 8'hFF)) begin
            failures++;
            $display("FAIL reset_blank edge=%0d got sel=%b led=%h want sel=1111 led=ff", n, seg_sel, seg_led);
         end
         if (n == 3 && (seg_sel !== 4'b1110 || seg_led !== 8'h90)) begin
            failures++;
            $display("FAIL reset_first_lit got sel=%b led=%h want sel=1110 led=90", seg_sel, seg_led);
         end
      end
   endtask

   task automatic test_scan_order;
      logic [7:0] exp_led [4];
      logic [3:0] es;
      logic [7:0] el;
      exp_led = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
      set_digits(4'd1, 4'd2, 4'd3, 4'd4);
      load = 1'b1; blank_lz = 1'b0; dp_en = 4'b0000;
      apply_reset(1);
      for (int f = 0; f < 2; f++) begin
         capture_frame(1'b0);
         for (int i = 0; i < 40; i++) begin
            es = (i % 10 < 2) ? 4'b1111 : sel_tab[i / 10];
            el = (i % 10 < 2) ? 8'hFF   : exp_led[i / 10];
            checks++;
            if (cap_sel[i] !== es || cap_led[i] !== el) begin
               failures++;
               $display("FAIL scan_order frame=%0d i=%0d got sel=%b led=%h want sel=%b led=%h", f, i, cap_sel[i], cap_led[i], es, el);
            end
         end
      end
   endtask

   task automatic test_leading_zero;
      logic [3:0]  vals [3];
      logic        blz  [3];
      logic [7:0]  exp_led [3][4];
      logic [3:0]  es;
      logic [7:0]  el;
      vals = '{4'd7, 4'd0, 4'd7};
      blz  = '{1'b1, 1'b1, 1'b0};
      exp_led[0] = '{8'hF8, 8'hFF, 8'hFF, 8'hFF};
      exp_led[1] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
      exp_led[2] = '{8'hF8, 8'hC0, 8'hC0, 8'hC0};
      for (int c = 0; c < 3; c++) begin
         set_digits(4'd0, 4'd0, 4'd0, vals[c]);
         load = 1'b1; blank_lz = blz[c]; dp_en = 4'b0000;
         apply_reset(1);
         capture_frame(1'b0);
         for (int i = 0; i < 40; i++) begin
            es = (i % 10 < 2) ? 4'b1111 : sel_tab[i / 10];
            el = (i % 10 < 2) ? 8'hFF   : exp_led[c][i / 10];
            checks++;
            if (cap_sel[i] !== es || cap_led[i] !== el) begin
               failures++;
               $display("FAIL leading_zero case=%0d i=%0d got sel=%b led=%h want sel=%b led=%h", c, i, cap_sel[i], cap_led[i], es, el);
            end
         end
      end
   endtask

   task automatic test_invalid_dp;
      logic [7:0] exp_led [4];
      logic [3:0] es;
      logic [7:0] el;
      exp_led = '{8'h92, 8'h3F, 8'hFF, 8'hFF};
      set_digits(4'd0, 4'd0, 4'hC, 4'd5);
      load = 1'b1; blank_lz = 1'b1; dp_en = 4'b0010;
      apply_reset(1);
      capture_frame(1'b0);
      for (int i = 0; i < 40; i++) begin
         es = (i % 10 < 2) ? 4'b1111 : sel_tab[i / 10];
         el = (i % 10 < 2) ? 8'hFF   : exp_led[i / 10];
         checks++;
         if (cap_sel[i] !== es || cap_led[i] !== el) begin
            failures++;
            $display("FAIL invalid_dp i=%0d got sel=%b led=%h want sel=%b led=%h", i, cap_sel[i], cap_led[i], es, el);
         end
      end
      dp_en = 4'b0000;
      blank_lz = 1'b0;
   endtask

   task automatic test_hold;
      logic [7:0] exp_led [3][4];
      logic [3:0] es;
      logic [7:0] el;
      exp_led[0] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
      exp_led[1] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
      exp_led[2] = '{8'h80, 8'hF8, 8'h82, 8'h92};
      set_digits(4'd1, 4'd2, 4'd3, 4'd4);
      load = 1'b1; blank_lz = 1'b0; dp_en = 4'b0000;
      apply_reset(1);
      for (int f = 0; f < 3; f++) begin
         if (f == 1) begin
            load = 1'b0;
            set_digits(4'd5, 4'd6, 4'd7, 4'd8);
         end
         if (f == 2) load = 1'b1;
         capture_frame(f == 2);
         for (int i = 0; i < 40; i++) begin
            es = (i % 10 < 2) ? 4'b1111 : sel_tab[i / 10];
            el = (i % 10 < 2) ? 8'hFF   : exp_led[f][i / 10];
            checks++;
            if (cap_sel[i] !== es || cap_led[i] !== el) begin
               failures++;
               $display("FAIL hold frame=%0d i=%0d got sel=%b led=%h want sel=%b led=%h", f, i, cap_sel[i], cap_led[i], es, el);
            end
         end
      end
   endtask

   task automatic test_load_tracking;
      logic [3:0] vals [6];
      logic [7:0] exp_led [6];
      vals    = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
      exp_led = '{8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
      set_digits(4'd1, 4'd2, 4'd3, 4'd4);
      load = 1'b1; blank_lz = 1'b0; dp_en = 4'b0000;
      apply_reset(1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      for (int k = 0; k < 6; k++) begin
         seg0 = vals[k];
         @(posedge clk); #1;
         checks++;
         if (seg_sel !== 4'b1110 || seg_led !== exp_led[k]) begin
            failures++;
            $display("FAIL load_track k=%0d got sel=%b led=%h want sel=1110 led=%h", k, seg_sel, seg_led, exp_led[k]);
         end
      end
   endtask

   task automatic test_midscan_reset;
      logic [7:0] exp_led [4];
      logic [3:0] es;
      logic [7:0] el;
      exp_led = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
      set_digits(4'd1, 4'd2, 4'd3, 4'd4);
      load = 1'b1; blank_lz = 1'b0; dp_en = 4'b0000;
      apply_reset(1);
      repeat (25) begin
         @(posedge clk); #1;
      end
      checks++;
      if (seg_sel !== 4'b1011 || seg_led !== 8'hA4) begin
         failures++;
         $display("FAIL midscan_pre got sel=%b led=%h want sel=1011 led=a4", seg_sel, seg_led);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (seg_sel !== 4'b1111 || seg_led !== 8'hFF) begin
         failures++;
         $display("FAIL midscan_reset got sel=%b led=%h want sel=1111 led=ff", seg_sel, seg_led);
      end
      rst_n = 1'b1;
      capture_frame(1'b0);
      for (int i = 0; i < 40; i++) begin
         es = (i % 10 < 2) ? 4'b1111 : sel_tab[i / 10];
         el = (i % 10 < 2) ? 8'hFF   : exp_led[i / 10];
         checks++;
         if (cap_sel[i] !== es || cap_led[i] !== el) begin
            failures++;
            $display("FAIL midscan_restart i=%0d got sel=%b led=%h want sel=%b led=%h", i, cap_sel[i], cap_led[i], es, el);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      load = 1'b0; blank_lz = 1'b0; dp_en = 4'b0000;
      set_digits(4'd0, 4'd0, 4'd0, 4'd0);
      #2;
      test_reset;
      test_scan_order;
      test_leading_zero;
      test_invalid_dp;
      test_hold;
      test_load_tracking;
      test_midscan_reset;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
